// File: rtl/alu_issue_queue.sv
// Issue queue in front of a combinational 32-bit ALU: buffers commands, issues
// one per cycle through a registered stage and returns tagged results in order.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [31:0]              IN_A,
    input  logic [31:0]              IN_B,
    input  logic [3:0]               IN_INST,
    input  logic                     IN_SEL,
    input  logic [TAGW-1:0]          IN_TAG,
    output logic [31:0]              A,
    output logic [31:0]              B,
    output logic [3:0]               INST,
    output logic                     SEL,
    input  logic [31:0]              Z,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [31:0]              OUT_Z,
    output logic [TAGW-1:0]          OUT_TAG,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic            sel;
        logic [3:0]      inst;
        logic [31:0]     b;
        logic [31:0]     a;
    } cmd_t;

    cmd_t mem [DEPTH];

    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic [31:0]     a_reg, b_reg;
    logic [3:0]      inst_reg;
    logic            sel_reg;
    logic [TAGW-1:0] itag_reg;
    logic            iv_reg;
    logic            ov_reg;
    logic [31:0]     oz_reg;
    logic [TAGW-1:0] otag_reg;

    logic push, pop, ofree, adv, capture;

    // Readiness looks only at the registered occupancy so a pop never opens
    // a slot for a push within the same cycle.
    assign IN_READY = (count_reg < FULL_CNT) && RST_N;
    assign push     = IN_VALID && IN_READY;
    assign ofree    = !ov_reg || OUT_READY;
    assign adv      = !iv_reg || ofree;
    assign pop      = adv && (count_reg != '0);
    assign capture  = iv_reg && ofree;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= '{tag: IN_TAG, sel: IN_SEL, inst: IN_INST, b: IN_B, a: IN_A};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Issue register doubles as the registered read port of the command RAM.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_reg    <= '0;
            b_reg    <= '0;
            inst_reg <= '0;
            sel_reg  <= 1'b0;
            itag_reg <= '0;
            iv_reg   <= 1'b0;
        end else if (adv) begin
            iv_reg <= pop;
            if (pop) begin
                a_reg    <= mem[rd_ptr_reg].a;
                b_reg    <= mem[rd_ptr_reg].b;
                inst_reg <= mem[rd_ptr_reg].inst;
                sel_reg  <= mem[rd_ptr_reg].sel;
                itag_reg <= mem[rd_ptr_reg].tag;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ov_reg   <= 1'b0;
            oz_reg   <= '0;
            otag_reg <= '0;
        end else if (capture) begin
            ov_reg   <= 1'b1;
            oz_reg   <= Z;
            otag_reg <= itag_reg;
        end else if (OUT_READY) begin
            ov_reg <= 1'b0;
        end
    end

    assign A         = a_reg;
    assign B         = b_reg;
    assign INST      = inst_reg;
    assign SEL       = sel_reg;
    assign OUT_VALID = ov_reg;
    assign OUT_Z     = oz_reg;
    assign OUT_TAG   = otag_reg;
    assign COUNT     = count_reg;

endmodule
